sv32_page_walker: RTL and testbench
===================================

// Module: sv32_page_walker
// PURPOSE
//  Hardware Sv32 page-table walker: on a TLB miss it sequences one or two 32-bit PTE reads
//  (level 1, then level 0) over a single memory read port, checks the PTEs and returns one
//  fill/fault result to the TLB. Sits between the 32-entry TLB and the D-side memory port.
//  Handles one walk at a time.
// PARAMETERS
//  PA_WD     34  physical address width ({PPN, VPN, 2'b00} = 22+10+2)
//  PPN_WD    22  physical page number width (PTE[31:10], satp.PPN)
//  VPN_WD    10  per-level VPN width (VPN1 = VA[31:22], VPN0 = VA[21:12])
//  ASID_WD    9  address-space id width, carried through unchanged
// PORTS
//  clk             in   1       clock
//  rst             in   1       reset, asynchronous, active-low
//  flush           in   1       sfence/abort: kill the walk in flight
//  walk_req_valid  in   1       TLB miss request
//  walk_req_ready  out  1       high only in IDLE with flush=0
//  walk_vpn1       in   VPN_WD  missing VA[31:22]
//  walk_vpn0       in   VPN_WD  missing VA[21:12]
//  walk_asid       in   ASID_WD ASID of the miss
//  satp_ppn        in   PPN_WD  root page-table PPN, sampled at request accept
//  mem_req_valid   out  1       PTE read request
//  mem_req_ready   in   1       memory accepts request
//  mem_req_addr    out  PA_WD   PTE byte address
//  mem_rsp_valid   in   1       read data valid (exactly one per accepted request)
//  mem_rsp_data    in   32      PTE
//  fill_valid      out  1       one-cycle result pulse, no backpressure
//  fill_vpn1/vpn0  out  VPN_WD  echoed request VPNs
//  fill_asid       out  ASID_WD echoed ASID
//  fill_ppn        out  PPN_WD  leaf PTE PPN (0 on fault)
//  fill_flags      out  8       leaf PTE[7:0] = D A G U X W R V (0 on fault)
//  fill_super      out  1       leaf found at level 1 (4 MiB page)
//  fill_fault      out  1       page fault; TLB must not cache the entry
//  busy            out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except walk_req_ready=1; captured request regs 0.
//  FSM: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE, DRAIN.
//  IDLE: valid&ready -> capture vpn1/vpn0/asid/satp_ppn; -> L1_REQ.
//  Lx_REQ: mem_req_valid=1, addr stable; L1 addr = {satp_ppn, vpn1, 2'b00},
//   L0 addr = {pte.PPN, vpn0, 2'b00}; handshake -> Lx_WAIT.
//  Lx_WAIT: on mem_rsp_valid decode PTE, registered same edge:
//   invalid (V=0 or R=0&W=1) -> fault; pointer (V=1,R=W=X=0): L1 -> L0_REQ, L0 -> fault;
//   leaf (R|X): fault if A=0, or if level 1 and PTE[19:10]!=0 (misaligned superpage);
//   else fill_ppn=PTE[31:10], fill_flags=PTE[7:0], fill_super=(level1).
//   Every terminal outcome -> DONE.
//  DONE: fill_valid = ~flush for exactly this cycle; -> IDLE. A new request can be accepted
//   the cycle after DONE.
//  Latency, 1-cycle memory, no stalls: accept T, L1 req T+1, rsp T+2, fill T+3 (superpage)
//   or L0 req T+3, rsp T+4, fill T+5.
//  flush in Lx_REQ: handshake same cycle -> DRAIN, else -> IDLE (request may be withdrawn).
//  flush in Lx_WAIT: rsp same cycle -> IDLE (data dropped), else -> DRAIN.
//  DRAIN: ready=0, wait for the single outstanding rsp, discard, -> IDLE. No fill from a
//   flushed walk. flush in IDLE: no accept that cycle.
//  Reserved PTE[9:8] ignored; D/U/G are only forwarded, never checked.
// TESTING
//  2-level: satp 0x00010, vpn1 0x001, vpn0 0x002; rsp1 0x00008001, rsp2 0x048D14C7 ->
//   addrs 0x10004, 0x20008; fill ppn 0x12345, flags 0xC7, super 0, fault 0.
//  Superpage: vpn1 0x3FF, rsp 0x0010004B -> single req addr 0x10FFC; fill ppn 0x00400,
//   flags 0x4B, super 1.
//  Faults: L1 PTE 0x00000000; L1 PTE 0x0010044B (misaligned); L0 PTE 0x00008001 (pointer);
//   leaf with A=0 -> each gives fill_fault=1, ppn 0, flags 0.
//  Flush in L0_WAIT, rsp 3 cycles later -> no fill_valid, ready=0 until rsp, ready=1 next cycle.
//  mem_req_ready low 5 cycles -> addr/valid held stable, exactly one handshake per level.
//  Reset asserted mid-L1_WAIT -> immediate IDLE outputs; late rsp_valid ignored.

Source files
------------

// File: rtl/sv32_page_walker.sv
// -----------------------------------------------------------------------------
// sv32_page_walker
//
// Hardware Sv32 page-table walker. On a TLB miss it reads the level-1 PTE and,
// if that PTE points to a next-level table, the level-0 PTE, over a single
// 32-bit memory read port. It checks the leaf PTE and returns exactly one
// fill or fault result to the TLB. Only one walk is in flight at a time.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   flush               kill the walk in flight (sfence / abort)
//   walk_req_*          miss request from the TLB (VPN1, VPN0, ASID)
//   satp_ppn            root table PPN, sampled when a request is accepted
//   mem_req_*           PTE read request (valid/ready handshake, byte address)
//   mem_rsp_*           PTE read data, exactly one beat per accepted request
//   fill_*              one-cycle result pulse towards the TLB, no backpressure
//   busy                walker is not idle
// -----------------------------------------------------------------------------
module sv32_page_walker #(
    parameter int PA_WD   = 34,
    parameter int PPN_WD  = 22,
    parameter int VPN_WD  = 10,
    parameter int ASID_WD = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               walk_req_valid,
    output logic               walk_req_ready,
    input  logic [VPN_WD-1:0]  walk_vpn1,
    input  logic [VPN_WD-1:0]  walk_vpn0,
    input  logic [ASID_WD-1:0] walk_asid,
    input  logic [PPN_WD-1:0]  satp_ppn,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [PA_WD-1:0]   mem_req_addr,
    input  logic               mem_rsp_valid,
    input  logic [31:0]        mem_rsp_data,
    output logic               fill_valid,
    output logic [VPN_WD-1:0]  fill_vpn1,
    output logic [VPN_WD-1:0]  fill_vpn0,
    output logic [ASID_WD-1:0] fill_asid,
    output logic [PPN_WD-1:0]  fill_ppn,
    output logic [7:0]         fill_flags,
    output logic               fill_super,
    output logic               fill_fault,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_L1_REQ  = 3'd1,
        S_L1_WAIT = 3'd2,
        S_L0_REQ  = 3'd3,
        S_L0_WAIT = 3'd4,
        S_DONE    = 3'd5,
        S_DRAIN   = 3'd6
    } state_t;

    // PTE is invalid when V=0 or when it encodes the reserved W-without-R case.
    function automatic logic pte_invalid(input logic [31:0] pte);
        return (~pte[0]) | (~pte[1] & pte[2]);
    endfunction

    // A valid PTE with R=W=X=0 points to the next-level table.
    function automatic logic pte_pointer(input logic [31:0] pte);
        return pte[0] & ~pte[1] & ~pte[2] & ~pte[3];
    endfunction

    state_t              state_q, state_d;
    logic [VPN_WD-1:0]   vpn1_q, vpn1_d;
    logic [VPN_WD-1:0]   vpn0_q, vpn0_d;
    logic [ASID_WD-1:0]  asid_q, asid_d;
    // Table base for the current level: satp.PPN for level 1, pointer PPN for level 0.
    logic [PPN_WD-1:0]   base_ppn_q, base_ppn_d;
    logic [PPN_WD-1:0]   fill_ppn_q, fill_ppn_d;
    logic [7:0]          fill_flags_q, fill_flags_d;
    logic                fill_super_q, fill_super_d;
    logic                fill_fault_q, fill_fault_d;
    logic                lvl1_s;

    // State and captured-request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            vpn1_q       <= {VPN_WD{1'b0}};
            vpn0_q       <= {VPN_WD{1'b0}};
            asid_q       <= {ASID_WD{1'b0}};
            base_ppn_q   <= {PPN_WD{1'b0}};
            fill_ppn_q   <= {PPN_WD{1'b0}};
            fill_flags_q <= 8'h00;
            fill_super_q <= 1'b0;
            fill_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vpn1_q       <= vpn1_d;
            vpn0_q       <= vpn0_d;
            asid_q       <= asid_d;
            base_ppn_q   <= base_ppn_d;
            fill_ppn_q   <= fill_ppn_d;
            fill_flags_q <= fill_flags_d;
            fill_super_q <= fill_super_d;
            fill_fault_q <= fill_fault_d;
        end
    end

    // Next-state logic and PTE decode.
    always_comb begin
        state_d      = state_q;
        vpn1_d       = vpn1_q;
        vpn0_d       = vpn0_q;
        asid_d       = asid_q;
        base_ppn_d   = base_ppn_q;
        fill_ppn_d   = fill_ppn_q;
        fill_flags_d = fill_flags_q;
        fill_super_d = fill_super_q;
        fill_fault_d = fill_fault_q;
        lvl1_s       = (state_q == S_L1_WAIT);

        case (state_q)
            S_IDLE: begin
                if (walk_req_valid && !flush) begin
                    vpn1_d     = walk_vpn1;
                    vpn0_d     = walk_vpn0;
                    asid_d     = walk_asid;
                    base_ppn_d = satp_ppn;
                    state_d    = S_L1_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_L1_REQ, S_L0_REQ: begin
                // A request accepted in the flush cycle still owes us a response.
                if (flush) begin
                    if (mem_req_ready) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (mem_req_ready) begin
                    if (state_q == S_L1_REQ) begin
                        state_d = S_L1_WAIT;
                    end else begin
                        state_d = S_L0_WAIT;
                    end
                end else begin
                    state_d = state_q;
                end
            end

            S_L1_WAIT, S_L0_WAIT: begin
                if (mem_rsp_valid) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else if (pte_invalid(mem_rsp_data)) begin
                        fill_ppn_d   = {PPN_WD{1'b0}};
                        fill_flags_d = 8'h00;
                        fill_super_d = 1'b0;
                        fill_fault_d = 1'b1;
                        state_d      = S_DONE;
                    end else if (pte_pointer(mem_rsp_data)) begin
                        if (lvl1_s) begin
                            base_ppn_d = mem_rsp_data[31:10];
                            state_d    = S_L0_REQ;
                        end else begin
                            // Pointer at the last level has nowhere to go.
                            fill_ppn_d   = {PPN_WD{1'b0}};
                            fill_flags_d = 8'h00;
                            fill_super_d = 1'b0;
                            fill_fault_d = 1'b1;
                            state_d      = S_DONE;
                        end
                    end else if (!mem_rsp_data[6] ||
                                 (lvl1_s && (mem_rsp_data[19:10] != 10'd0))) begin
                        // Leaf with A=0, or a 4 MiB superpage whose PPN0 is not zero.
                        fill_ppn_d   = {PPN_WD{1'b0}};
                        fill_flags_d = 8'h00;
                        fill_super_d = 1'b0;
                        fill_fault_d = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        fill_ppn_d   = mem_rsp_data[31:10];
                        fill_flags_d = mem_rsp_data[7:0];
                        fill_super_d = lvl1_s;
                        fill_fault_d = 1'b0;
                        state_d      = S_DONE;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = state_q;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_DRAIN: begin
                if (mem_rsp_valid) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign walk_req_ready = (state_q == S_IDLE) & ~flush;
    assign mem_req_valid  = (state_q == S_L1_REQ) | (state_q == S_L0_REQ);
    assign mem_req_addr   = {base_ppn_q, (state_q == S_L0_REQ) ? vpn0_q : vpn1_q, 2'b00};
    assign fill_valid     = (state_q == S_DONE) & ~flush;
    assign fill_vpn1      = vpn1_q;
    assign fill_vpn0      = vpn0_q;
    assign fill_asid      = asid_q;
    assign fill_ppn       = fill_ppn_q;
    assign fill_flags     = fill_flags_q;
    assign fill_super     = fill_super_q;
    assign fill_fault     = fill_fault_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_sv32_page_walker.sv
// -----------------------------------------------------------------------------
// tb_sv32_page_walker
//
// Directed bench for the Sv32 walker. A small memory model returns PTEs from a
// queue of expected requests; expected fill results are queued when a walk is
// started and compared when fill_valid pulses.
// -----------------------------------------------------------------------------
module tb_sv32_page_walker;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        walk_req_valid;
    logic        walk_req_ready;
    logic [9:0]  walk_vpn1;
    logic [9:0]  walk_vpn0;
    logic [8:0]  walk_asid;
    logic [21:0] satp_ppn;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [33:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        fill_valid;
    logic [9:0]  fill_vpn1;
    logic [9:0]  fill_vpn0;
    logic [8:0]  fill_asid;
    logic [21:0] fill_ppn;
    logic [7:0]  fill_flags;
    logic        fill_super;
    logic        fill_fault;
    logic        busy;

    sv32_page_walker dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .walk_req_valid (walk_req_valid),
        .walk_req_ready (walk_req_ready),
        .walk_vpn1      (walk_vpn1),
        .walk_vpn0      (walk_vpn0),
        .walk_asid      (walk_asid),
        .satp_ppn       (satp_ppn),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .fill_valid     (fill_valid),
        .fill_vpn1      (fill_vpn1),
        .fill_vpn0      (fill_vpn0),
        .fill_asid      (fill_asid),
        .fill_ppn       (fill_ppn),
        .fill_flags     (fill_flags),
        .fill_super     (fill_super),
        .fill_fault     (fill_fault),
        .busy           (busy)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  vpn1;
        logic [9:0]  vpn0;
        logic [8:0]  asid;
        logic [21:0] ppn;
        logic [7:0]  flags;
        logic        sup;
        logic        fault;
    } fill_t;

    typedef struct packed {
        logic [33:0] addr;
        logic [31:0] data;
        logic [7:0]  dly;
    } mem_t;

    fill_t       fill_q[$];
    int          lat_q[$];
    mem_t        mem_q[$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          hs_cnt = 0;
    int          stall_cnt = 0;
    int          rsp_cnt = -1;
    int          ready_hold = 0;
    logic [31:0] pend_data = 32'h0;
    logic        req_pend = 1'b0;
    logic [9:0]  s_vpn1 = 10'h0;
    logic [9:0]  s_vpn0 = 10'h0;
    logic [8:0]  s_asid = 9'h0;
    logic [21:0] s_satp = 22'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_mem(input logic [33:0] a, input logic [31:0] d, input logic [7:0] dly);
        mem_t m;
        m.addr = a;
        m.data = d;
        m.dly  = dly;
        mem_q.push_back(m);
    endtask

    task automatic push_fill(input logic [9:0] v1, input logic [9:0] v0, input logic [8:0] a,
                             input logic [21:0] ppn, input logic [7:0] fl, input logic sp,
                             input logic flt, input int lat);
        fill_t f;
        f.vpn1  = v1;
        f.vpn0  = v0;
        f.asid  = a;
        f.ppn   = ppn;
        f.flags = fl;
        f.sup   = sp;
        f.fault = flt;
        fill_q.push_back(f);
        lat_q.push_back(lat);
    endtask

    task automatic start_walk(input logic [9:0] v1, input logic [9:0] v0,
                              input logic [8:0] a, input logic [21:0] satp);
        s_vpn1   = v1;
        s_vpn0   = v0;
        s_asid   = a;
        s_satp   = satp;
        req_pend = 1'b1;
    endtask

    // One clock cycle: drive inputs at the falling edge, then sample and score.
    task automatic step(input logic fl);
        mem_t  m;
        fill_t f;
        int    l;
        @(negedge clk);
        cyc++;
        if (rsp_cnt == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = pend_data;
            rsp_cnt       = -1;
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = 32'h0;
            if (rsp_cnt > 0) rsp_cnt--;
        end
        if (ready_hold > 0 && mem_req_valid) begin
            mem_req_ready = 1'b0;
            ready_hold--;
        end else begin
            mem_req_ready = 1'b1;
        end
        flush          = fl;
        walk_req_valid = req_pend;
        walk_vpn1      = s_vpn1;
        walk_vpn0      = s_vpn0;
        walk_asid      = s_asid;
        satp_ppn       = s_satp;
        #1;
        if (walk_req_valid && walk_req_ready) begin
            req_pend = 1'b0;
            acc_cyc  = cyc;
        end
        if (mem_req_valid && mem_req_ready) begin
            hs_cnt++;
            if (mem_q.size() == 0) begin
                chk("unexpected_mem_req", {63'h0, mem_req_valid}, 64'h0);
            end else begin
                m = mem_q.pop_front();
                chk("mem_addr", {30'h0, mem_req_addr}, {30'h0, m.addr});
                pend_data = m.data;
                rsp_cnt   = int'(m.dly) - 1;
            end
        end else if (mem_req_valid) begin
            stall_cnt++;
            if (mem_q.size() != 0) chk("mem_addr_hold", {30'h0, mem_req_addr}, {30'h0, mem_q[0].addr});
        end
        if (fill_valid) begin
            if (fill_q.size() == 0) begin
                chk("unexpected_fill", {63'h0, fill_valid}, 64'h0);
            end else begin
                f = fill_q.pop_front();
                l = lat_q.pop_front();
                chk("fill", {3'h0, fill_vpn1, fill_vpn0, fill_asid, fill_ppn, fill_flags,
                             fill_super, fill_fault}, {3'h0, f});
                if (l >= 0) chk("fill_latency", 64'(cyc - acc_cyc), 64'(l));
            end
        end
    endtask

    // Run cycles until the walk and all scoreboard entries are retired.
    task automatic finish_walk(input int max);
        int n = 0;
        while ((req_pend || busy || fill_q.size() != 0 || mem_q.size() != 0 || rsp_cnt >= 0)
               && n < max) begin
            step(1'b0);
            n++;
        end
        total++;
        assert (n < max) else begin
            bad++;
            $error("FAIL walk_timeout: cycles=%0d limit=%0d", n, max);
        end
    endtask

    task automatic wait_hs(input int target, input int max);
        int n = 0;
        while (hs_cnt < target && n < max) begin
            step(1'b0);
            n++;
        end
        total++;
        assert (hs_cnt >= target) else begin
            bad++;
            $error("FAIL handshake_timeout: handshakes=%0d expected=%0d", hs_cnt, target);
        end
    endtask

    int hs0;
    int st0;

    initial begin
        rst            = 1'b0;
        flush          = 1'b0;
        walk_req_valid = 1'b0;
        walk_vpn1      = 10'h0;
        walk_vpn0      = 10'h0;
        walk_asid      = 9'h0;
        satp_ppn       = 22'h0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = 32'h0;

        // Reset values.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_walk_req_ready", {63'h0, walk_req_ready}, 64'h1);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_mem_req_valid", {63'h0, mem_req_valid}, 64'h0);
        chk("rst_mem_req_addr", {30'h0, mem_req_addr}, 64'h0);
        chk("rst_fill_valid", {63'h0, fill_valid}, 64'h0);
        chk("rst_fill_bus", {3'h0, fill_vpn1, fill_vpn0, fill_asid, fill_ppn, fill_flags,
                             fill_super, fill_fault}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        step(1'b0);

        // Two-level walk to a 4 KiB leaf.
        push_mem(34'h10004, 32'h00008001, 8'd1);
        push_mem(34'h20008, 32'h048D14C7, 8'd1);
        push_fill(10'h001, 10'h002, 9'h1A5, 22'h12345, 8'hC7, 1'b0, 1'b0, 5);
        hs0 = hs_cnt;
        start_walk(10'h001, 10'h002, 9'h1A5, 22'h00010);
        finish_walk(40);
        chk("handshakes_2level", 64'(hs_cnt - hs0), 64'd2);

        // Superpage leaf at level 1.
        push_mem(34'h10FFC, 32'h0010004B, 8'd1);
        push_fill(10'h3FF, 10'h155, 9'h0AA, 22'h00400, 8'h4B, 1'b1, 1'b0, 3);
        hs0 = hs_cnt;
        start_walk(10'h3FF, 10'h155, 9'h0AA, 22'h00010);
        finish_walk(40);
        chk("handshakes_super", 64'(hs_cnt - hs0), 64'd1);

        // Fault: invalid L1 PTE.
        push_mem(34'h10010, 32'h00000000, 8'd1);
        push_fill(10'h004, 10'h007, 9'h001, 22'h0, 8'h00, 1'b0, 1'b1, 3);
        start_walk(10'h004, 10'h007, 9'h001, 22'h00010);
        finish_walk(40);

        // Fault: misaligned superpage.
        push_mem(34'h10FFC, 32'h0010044B, 8'd1);
        push_fill(10'h3FF, 10'h000, 9'h002, 22'h0, 8'h00, 1'b0, 1'b1, 3);
        start_walk(10'h3FF, 10'h000, 9'h002, 22'h00010);
        finish_walk(40);

        // Fault: pointer at level 0.
        push_mem(34'h10004, 32'h00008001, 8'd1);
        push_mem(34'h20008, 32'h00008001, 8'd1);
        push_fill(10'h001, 10'h002, 9'h003, 22'h0, 8'h00, 1'b0, 1'b1, 5);
        start_walk(10'h001, 10'h002, 9'h003, 22'h00010);
        finish_walk(40);

        // Fault: level-0 leaf with A=0.
        push_mem(34'h10004, 32'h00008001, 8'd1);
        push_mem(34'h20008, 32'h048D1487, 8'd1);
        push_fill(10'h001, 10'h002, 9'h004, 22'h0, 8'h00, 1'b0, 1'b1, 5);
        start_walk(10'h001, 10'h002, 9'h004, 22'h00010);
        finish_walk(40);

        // Fault: reserved W-without-R encoding at level 1.
        push_mem(34'h10004, 32'h00000005, 8'd1);
        push_fill(10'h001, 10'h002, 9'h005, 22'h0, 8'h00, 1'b0, 1'b1, 3);
        start_walk(10'h001, 10'h002, 9'h005, 22'h00010);
        finish_walk(40);

        // Memory not ready for 5 cycles at level 1.
        ready_hold = 5;
        push_mem(34'h10004, 32'h00008001, 8'd1);
        push_mem(34'h20008, 32'h048D14C7, 8'd1);
        push_fill(10'h001, 10'h002, 9'h006, 22'h12345, 8'hC7, 1'b0, 1'b0, -1);
        hs0 = hs_cnt;
        st0 = stall_cnt;
        start_walk(10'h001, 10'h002, 9'h006, 22'h00010);
        finish_walk(60);
        chk("handshakes_stall", 64'(hs_cnt - hs0), 64'd2);
        chk("stall_cycles", 64'(stall_cnt - st0), 64'd5);

        // Flush in L0_WAIT; level-0 response arrives 3 cycles after its handshake.
        push_mem(34'h10004, 32'h00008001, 8'd1);
        push_mem(34'h20008, 32'h048D14C7, 8'd3);
        hs0 = hs_cnt;
        start_walk(10'h001, 10'h002, 9'h007, 22'h00010);
        wait_hs(hs0 + 2, 20);
        step(1'b1);
        chk("flush_wait_fill", {63'h0, fill_valid}, 64'h0);
        step(1'b0);
        chk("drain_ready_0", {63'h0, walk_req_ready}, 64'h0);
        chk("drain_busy", {63'h0, busy}, 64'h1);
        step(1'b0);
        chk("drain_rsp_mem_valid", {63'h0, mem_rsp_valid}, 64'h1);
        chk("drain_ready_1", {63'h0, walk_req_ready}, 64'h0);
        chk("drain_rsp_fill", {63'h0, fill_valid}, 64'h0);
        step(1'b0);
        chk("post_drain_ready", {63'h0, walk_req_ready}, 64'h1);
        chk("post_drain_busy", {63'h0, busy}, 64'h0);

        // Flush in IDLE blocks acceptance.
        start_walk(10'h001, 10'h002, 9'h008, 22'h00010);
        step(1'b1);
        chk("idle_flush_ready", {63'h0, walk_req_ready}, 64'h0);
        req_pend = 1'b0;
        step(1'b0);
        chk("idle_flush_busy", {63'h0, busy}, 64'h0);

        // Flush in L1_REQ without a handshake withdraws the request.
        ready_hold = 3;
        start_walk(10'h001, 10'h002, 9'h009, 22'h00010);
        step(1'b0);
        step(1'b0);
        chk("l1req_valid", {63'h0, mem_req_valid}, 64'h1);
        step(1'b1);
        step(1'b0);
        chk("l1req_flush_busy", {63'h0, busy}, 64'h0);
        chk("l1req_flush_mreq", {63'h0, mem_req_valid}, 64'h0);
        ready_hold = 0;

        // Reset asserted while waiting for the level-1 response.
        push_mem(34'h10004, 32'h0010004B, 8'd3);
        hs0 = hs_cnt;
        start_walk(10'h001, 10'h002, 9'h00A, 22'h00010);
        wait_hs(hs0 + 1, 20);
        step(1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_ready", {63'h0, walk_req_ready}, 64'h1);
        chk("midrst_busy", {63'h0, busy}, 64'h0);
        chk("midrst_mreq", {63'h0, mem_req_valid}, 64'h0);
        chk("midrst_fill", {63'h0, fill_valid}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) begin
            step(1'b0);
            chk("late_rsp_busy", {63'h0, busy}, 64'h0);
        end

        // Normal walk after reset recovery.
        push_mem(34'h10FFC, 32'h0010004B, 8'd1);
        push_fill(10'h3FF, 10'h001, 9'h1FF, 22'h00400, 8'h4B, 1'b1, 1'b0, 3);
        start_walk(10'h3FF, 10'h001, 9'h1FF, 22'h00010);
        finish_walk(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
